// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the five-stage pipeline.
// Holds the fetch PC, selects the next PC (sequential, taken branch, or a
// branch captured while fetch was stalled), drives the one-cycle-latency
// instruction SRAM and hands {inst, pc} to decode over valid/allowin.
//
// Ports:
//   clk              pipeline clock, rising edge
//   reset            asynchronous, active-high reset
//   ds_allowin       decode can accept an instruction this cycle
//   br_bus[32:0]     {br_taken, br_target} from decode
//   fs_to_ds_valid   fetch holds a valid instruction for decode
//   fs_to_ds_bus     {fs_inst[63:32], fs_pc[31:0]}
//   inst_sram_*      instruction SRAM read port (write side tied off)
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic [32:0] br_bus,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);

    localparam int unsigned PC_W = 32;

    logic            br_taken;
    logic [PC_W-1:0] br_target;

    logic            fs_valid;
    logic [PC_W-1:0] fs_pc;
    logic            fresh;
    logic            buf_valid;
    logic [PC_W-1:0] inst_buf;
    logic            br_pend;
    logic [PC_W-1:0] br_pend_target;

    logic            to_fs_valid;
    logic            fs_allowin;
    logic            accept;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] nextpc;
    logic [PC_W-1:0] fs_inst;

    assign br_taken  = br_bus[32];
    assign br_target = br_bus[31:0];

    // Pre-IF: next PC selection; a live branch beats a remembered one
    always_comb begin
        to_fs_valid = !reset;
        seq_pc      = fs_pc + PC_W'(4);
        if (br_taken) begin
            nextpc = br_target;
        end else if (br_pend) begin
            nextpc = br_pend_target;
        end else begin
            nextpc = seq_pc;
        end
        fs_allowin = !fs_valid || ds_allowin;
        accept     = to_fs_valid && fs_allowin;
    end

    // SRAM data for fs_pc is only present in the cycle right after the read,
    // so a stalled instruction is served from inst_buf afterwards
    assign fs_inst = buf_valid ? inst_buf : inst_sram_rdata;

    assign inst_sram_en    = accept;
    assign inst_sram_wen   = 4'h0;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'h0;

    assign fs_to_ds_valid = fs_valid;
    assign fs_to_ds_bus   = {fs_inst, fs_pc};

    // Fetch PC, valid and fresh-data tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fs_valid <= 1'b0;
            fs_pc    <= RESET_PC - PC_W'(4);
            fresh    <= 1'b0;
        end else begin
            fresh <= accept;
            if (accept) begin
                fs_valid <= 1'b1;
                fs_pc    <= nextpc;
            end
        end
    end

    // Remember a branch that arrives while fetch cannot accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_pend        <= 1'b0;
            br_pend_target <= '0;
        end else if (accept) begin
            br_pend <= 1'b0;
        end else if (br_taken && !fs_allowin) begin
            br_pend        <= 1'b1;
            br_pend_target <= br_target;
        end
    end

    // Capture the instruction on the first stalled cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid <= 1'b0;
            inst_buf  <= '0;
        end else if (accept) begin
            buf_valid <= 1'b0;
        end else if (fresh && fs_valid && !ds_allowin) begin
            buf_valid <= 1'b1;
            inst_buf  <= inst_sram_rdata;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: SRAM model with one-cycle latency that drives
// 0xdeadbeef whenever it is not read, plus a scoreboard of {inst, pc}
// entries pushed on each expected fetch and popped when decode takes them.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        ds_allowin;
    logic [32:0] br_bus;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] sb[$];

    if_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ds_allowin      (ds_allowin),
        .br_bus          (br_bus),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_to_ds_bus    (fs_to_ds_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a == 32'hbfc00008) ? 32'h24020001 : (a ^ 32'h5a5aa5a5);
    endfunction

    // Synchronous SRAM: data one cycle after an enabled read, junk otherwise
    always @(posedge clk) begin
        inst_sram_rdata <= inst_sram_en ? inst_of(inst_sram_addr) : 32'hdeadbeef;
    end

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (inst_sram_en !== 1'b0) begin
                n_fail++; $display("FAIL rst_en[%0d]: got %b want 0", i, inst_sram_en);
            end
            n_checks++;
            if (fs_to_ds_valid !== 1'b0) begin
                n_fail++; $display("FAIL rst_valid[%0d]: got %b want 0", i, fs_to_ds_valid);
            end
            n_checks++;
            if (inst_sram_addr !== 32'hbfc00000) begin
                n_fail++; $display("FAIL rst_addr[%0d]: got %h want bfc00000", i, inst_sram_addr);
            end
            n_checks++;
            if (inst_sram_wen !== 4'h0 || inst_sram_wdata !== 32'h0) begin
                n_fail++; $display("FAIL rst_wside[%0d]: got %h/%h want 0/0", i, inst_sram_wen, inst_sram_wdata);
            end
        end
    endtask

    // Reset release, sequential fetch, then a 3-cycle decode stall
    task automatic test_sequential_stall();
        logic        allow[8] = '{1, 1, 1, 0, 0, 0, 1, 1};
        logic [31:0] eaddr[8] = '{32'hbfc00000, 32'hbfc00004, 32'hbfc00008, 32'h0,
                                  32'h0, 32'h0, 32'hbfc0000c, 32'hbfc00010};
        logic exp_valid, exp_en;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            reset = 1'b0;
            ds_allowin = allow[i];
            br_bus = 33'h0;
            #1;
            exp_valid = (sb.size() != 0);
            exp_en = !exp_valid || allow[i];
            n_checks++;
            if (inst_sram_en !== exp_en) begin
                n_fail++; $display("FAIL seq_en[%0d]: got %b want %b", i, inst_sram_en, exp_en);
            end
            if (exp_en) begin
                n_checks++;
                if (inst_sram_addr !== eaddr[i]) begin
                    n_fail++; $display("FAIL seq_addr[%0d]: got %h want %h", i, inst_sram_addr, eaddr[i]);
                end
            end
            n_checks++;
            if (fs_to_ds_valid !== exp_valid) begin
                n_fail++; $display("FAIL seq_valid[%0d]: got %b want %b", i, fs_to_ds_valid, exp_valid);
            end
            if (!allow[i]) begin
                n_checks++;
                if (fs_to_ds_bus !== 64'h24020001_bfc00008) begin
                    n_fail++; $display("FAIL stall_hold[%0d]: got %h want 24020001bfc00008", i, fs_to_ds_bus);
                end
            end
            if (exp_valid) begin
                n_checks++;
                if (fs_to_ds_bus !== sb[0]) begin
                    n_fail++; $display("FAIL seq_bus[%0d]: got %h want %h", i, fs_to_ds_bus, sb[0]);
                end
                if (allow[i]) void'(sb.pop_front());
            end
            if (exp_en) sb.push_back({inst_of(eaddr[i]), eaddr[i]});
        end
    endtask

    // Taken branch, branch during stall, held branch, and PC wrap
    task automatic test_branch();
        logic        allow[14] = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        logic        bt[14]    = '{1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0};
        logic [31:0] tgt[14]   = '{32'hbfc00100, 32'h0, 32'h0, 32'hbfc00200, 32'h0, 32'h0, 32'h0,
                                   32'hbfc00300, 32'hbfc00300, 32'h0, 32'h0, 32'hfffffffc, 32'h0, 32'h0};
        logic [31:0] eaddr[14] = '{32'hbfc00100, 32'hbfc00104, 32'hbfc00108, 32'h0, 32'h0,
                                   32'hbfc00200, 32'hbfc00204, 32'h0, 32'h0, 32'hbfc00300,
                                   32'hbfc00304, 32'hfffffffc, 32'h00000000, 32'h00000004};
        logic exp_valid, exp_en;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            ds_allowin = allow[i];
            br_bus = {bt[i], tgt[i]};
            #1;
            exp_valid = (sb.size() != 0);
            exp_en = !exp_valid || allow[i];
            n_checks++;
            if (inst_sram_en !== exp_en) begin
                n_fail++; $display("FAIL br_en[%0d]: got %b want %b", i, inst_sram_en, exp_en);
            end
            if (exp_en) begin
                n_checks++;
                if (inst_sram_addr !== eaddr[i]) begin
                    n_fail++; $display("FAIL br_addr[%0d]: got %h want %h", i, inst_sram_addr, eaddr[i]);
                end
            end
            n_checks++;
            if (fs_to_ds_valid !== exp_valid) begin
                n_fail++; $display("FAIL br_valid[%0d]: got %b want %b", i, fs_to_ds_valid, exp_valid);
            end
            if (exp_valid) begin
                n_checks++;
                if (fs_to_ds_bus !== sb[0]) begin
                    n_fail++; $display("FAIL br_bus[%0d]: got %h want %h", i, fs_to_ds_bus, sb[0]);
                end
                if (allow[i]) void'(sb.pop_front());
            end
            if (exp_en) sb.push_back({inst_of(eaddr[i]), eaddr[i]});
        end
    endtask

    // Stall with a pending branch and a full buffer, then async reset
    task automatic test_reset_mid();
        logic        allow[6] = '{1, 0, 0, 1, 1, 1};
        logic        bt[6]    = '{0, 1, 0, 0, 0, 0};
        logic [31:0] eaddr[6] = '{32'h00000008, 32'h0, 32'h0,
                                  32'hbfc00000, 32'hbfc00004, 32'hbfc00008};
        logic exp_valid, exp_en;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                #2;
                reset = 1'b1;
                #1;
                n_checks++;
                if (fs_to_ds_valid !== 1'b0 || inst_sram_en !== 1'b0) begin
                    n_fail++; $display("FAIL rstmid_now: got valid=%b en=%b want 0/0", fs_to_ds_valid, inst_sram_en);
                end
                @(negedge clk);
                #1;
                n_checks++;
                if (inst_sram_en !== 1'b0 || fs_to_ds_valid !== 1'b0 || inst_sram_addr !== 32'hbfc00000) begin
                    n_fail++; $display("FAIL rstmid_hold: got en=%b valid=%b addr=%h want 0/0/bfc00000",
                                       inst_sram_en, fs_to_ds_valid, inst_sram_addr);
                end
                sb.delete();
            end
            @(negedge clk);
            reset = 1'b0;
            ds_allowin = allow[i];
            br_bus = {bt[i], 32'h12345678};
            #1;
            exp_valid = (sb.size() != 0);
            exp_en = !exp_valid || allow[i];
            n_checks++;
            if (inst_sram_en !== exp_en) begin
                n_fail++; $display("FAIL rstmid_en[%0d]: got %b want %b", i, inst_sram_en, exp_en);
            end
            if (exp_en) begin
                n_checks++;
                if (inst_sram_addr !== eaddr[i]) begin
                    n_fail++; $display("FAIL rstmid_addr[%0d]: got %h want %h", i, inst_sram_addr, eaddr[i]);
                end
            end
            n_checks++;
            if (fs_to_ds_valid !== exp_valid) begin
                n_fail++; $display("FAIL rstmid_valid[%0d]: got %b want %b", i, fs_to_ds_valid, exp_valid);
            end
            if (exp_valid) begin
                n_checks++;
                if (fs_to_ds_bus !== sb[0]) begin
                    n_fail++; $display("FAIL rstmid_bus[%0d]: got %h want %h", i, fs_to_ds_bus, sb[0]);
                end
                if (allow[i]) void'(sb.pop_front());
            end
            if (exp_en) sb.push_back({inst_of(eaddr[i]), eaddr[i]});
        end
    endtask

    initial begin
        reset      = 1'b1;
        ds_allowin = 1'b1;
        br_bus     = 33'h0;
        test_reset();
        test_sequential_stall();
        test_branch();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
